// File: rtl/pri_enc_pkg.sv
// Shared definitions for the sequential 8-to-3 priority encoder:
// the FSM state encoding and the default line/index widths.
package pri_enc_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = $clog2(N_DEF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage : pri_enc_pkg

// File: rtl/pri_enc_lsb.sv
// Combinational lowest-set-bit finder: index and one-hot mask of the
// lowest set line, plus "any bit set" and "exactly one bit set" flags.
module pri_enc_lsb
  import pri_enc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any,
  output logic         single
);

  // Two's-complement trick isolates the lowest set bit; a zero vector gives a zero mask.
  assign onehot = vec & (~vec + N'(1));
  assign any    = |vec;
  // Clearing the lowest set bit leaves nothing only when at most one bit was set.
  assign single = any && ((vec & (vec - N'(1))) == '0);

  // Scan from the top down so the lowest set line is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule : pri_enc_lsb

// File: rtl/pri_encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: accepts a multi-hot line vector and emits
// the index of each set line, lowest first, one per output handshake.
// An all-zero vector produces a single beat flagged with out_none.
module pri_encoder_8to3_seq
  import pri_enc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none,
  output logic         busy
);

  state_e         state_q;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   pending_d;
  logic           none_q;

  logic [W-1:0]   lsb_idx_s;
  logic [N-1:0]   lsb_onehot_s;
  logic           lsb_any_s;
  logic           lsb_single_s;
  logic           emit_s;
  logic           last_s;

  pri_enc_lsb #(
    .N (N),
    .W (W)
  ) u_lsb (
    .vec    (pending_q),
    .idx    (lsb_idx_s),
    .onehot (lsb_onehot_s),
    .any    (lsb_any_s),
    .single (lsb_single_s)
  );

  // All outputs derive from registered state only, so in_* never reaches out_* combinationally.
  assign emit_s    = (state_q == ST_EMIT);
  assign last_s    = !lsb_any_s || lsb_single_s;
  assign pending_d = pending_q & ~lsb_onehot_s;

  assign in_ready  = !emit_s;
  assign out_valid = emit_s;
  assign out_idx   = emit_s ? lsb_idx_s : '0;
  assign out_last  = emit_s && last_s;
  assign out_none  = emit_s && none_q;
  assign busy      = emit_s;

  // FSM: capture a vector in IDLE, then retire one set line per accepted beat in EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            pending_q <= in_vec;
            none_q    <= (in_vec == '0);
            state_q   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (last_s) begin
              state_q   <= ST_IDLE;
              pending_q <= '0;
              none_q    <= 1'b0;
            end else begin
              pending_q <= pending_d;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pending_q <= '0;
          none_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule : pri_encoder_8to3_seq
